// File: rtl/menu_pkg.sv
// Shared constants, state type and cursor geometry helper for the title-menu cursor.
package menu_pkg;

    localparam logic [7:0] KEY_PAGEUP = 8'h4B;
    localparam logic [7:0] KEY_PAGEDN = 8'h4E;
    localparam logic [7:0] KEY_ENTER  = 8'h28;

    localparam int Y_BASE_DEF = 276;
    localparam int Y_STEP_DEF = 64;

    typedef enum logic {
        NAV    = 1'b0,
        LOCKED = 1'b1
    } menu_state_t;

    // Screen Y of an entry; wraps modulo 1024 to fit the 10-bit sprite bus.
    function automatic logic [9:0] cursor_y(input int base, input int step, input int idx);
        return 10'(base + idx * step);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Press-edge detector plus hold-to-repeat timer for one navigation key.
module key_repeat
    import menu_pkg::*;
#(
    parameter logic [7:0] KEY          = KEY_PAGEDN,
    parameter int         REPEAT_DELAY = 30,
    parameter int         REPEAT_RATE  = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] prev_key,
    output logic       step
);

    localparam logic [15:0] DELAY_C = 16'(REPEAT_DELAY);
    localparam logic [15:0] RATE_C  = 16'(REPEAT_RATE);

    logic [15:0] cnt_r;
    logic [15:0] cnt_inc_s;
    logic        rep_r;
    logic        press_s;
    logic        hold_s;
    logic        fire_s;

    // Edge/hold decode; the target switches from the initial delay to the rate after the first repeat.
    always_comb begin
        press_s   = (keycode == KEY) && (prev_key != KEY);
        hold_s    = (keycode == KEY) && (prev_key == KEY);
        cnt_inc_s = cnt_r + 16'd1;
        fire_s    = hold_s && (cnt_inc_s == (rep_r ? RATE_C : DELAY_C));
        step      = press_s || fire_s;
    end

    // Hold-frame counter; any keycode change drops back to the initial-delay phase.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            cnt_r <= 16'd0;
            rep_r <= 1'b0;
        end else if (!hold_s) begin
            cnt_r <= 16'd0;
            rep_r <= 1'b0;
        end else if (fire_s) begin
            cnt_r <= 16'd0;
            rep_r <= 1'b1;
        end else begin
            cnt_r <= cnt_inc_s;
            rep_r <= rep_r;
        end
    end

endmodule

// File: rtl/menu_cursor.sv
// Title-menu cursor: keyboard navigation over NUM_OPTS entries with confirm/lock handshake.
module menu_cursor
    import menu_pkg::*;
#(
    parameter int         NUM_OPTS     = 2,
    parameter int         X_POS        = 155,
    parameter int         Y_BASE       = Y_BASE_DEF,
    parameter int         Y_STEP       = Y_STEP_DEF,
    parameter int         RESET_IDX    = 0,
    parameter bit         WRAP         = 1'b0,
    parameter logic [7:0] KEY_PREV     = KEY_PAGEUP,
    parameter logic [7:0] KEY_NEXT     = KEY_PAGEDN,
    parameter logic [7:0] KEY_SEL      = KEY_ENTER,
    parameter int         REPEAT_DELAY = 30,
    parameter int         REPEAT_RATE  = 8
) (
    input  logic                        frame_clk,
    input  logic                        Reset,
    input  logic [7:0]                  keycode,
    input  logic                        st,
    input  logic                        unlock,
    output logic [9:0]                  CursorX,
    output logic [9:0]                  CursorY,
    output logic [$clog2(NUM_OPTS)-1:0] sel_idx,
    output logic [NUM_OPTS-1:0]         mode_onehot,
    output logic                        confirm,
    output logic                        locked
);

    localparam int SW = $clog2(NUM_OPTS);
    localparam int IW = SW + 1;
    localparam logic [IW-1:0]       LAST_IDX     = IW'(NUM_OPTS - 1);
    localparam logic [SW-1:0]       RESET_SEL    = SW'(RESET_IDX);
    localparam logic [NUM_OPTS-1:0] RESET_ONEHOT = {{(NUM_OPTS-1){1'b0}}, 1'b1} << RESET_IDX;

    logic [7:0]          prev_key_r;
    logic                prev_step_s;
    logic                next_step_s;
    logic                sel_edge_s;
    menu_state_t         state_r;
    menu_state_t         state_s;
    logic [SW-1:0]       sel_r;
    logic [IW-1:0]       idx_s;
    logic [9:0]          cursor_y_r;
    logic [NUM_OPTS-1:0] onehot_r;
    logic [NUM_OPTS-1:0] onehot_s;
    logic                confirm_r;
    logic                confirm_s;
    logic                locked_r;

    key_repeat #(.KEY(KEY_PREV), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_prev (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .prev_key  (prev_key_r),
        .step      (prev_step_s)
    );

    key_repeat #(.KEY(KEY_NEXT), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_next (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .prev_key  (prev_key_r),
        .step      (next_step_s)
    );

    assign sel_edge_s  = (keycode == KEY_SEL) && (prev_key_r != KEY_SEL);
    assign CursorX     = 10'(X_POS);
    assign CursorY     = cursor_y_r;
    assign sel_idx     = sel_r;
    assign mode_onehot = onehot_r;
    assign confirm     = confirm_r;
    assign locked      = locked_r;

    // Next state, next index and confirm strobe; unlock is honoured even while st is high.
    always_comb begin
        state_s   = state_r;
        idx_s     = {1'b0, sel_r};
        confirm_s = 1'b0;
        case (state_r)
            NAV: begin
                if (st) begin
                    state_s = NAV;
                end else if (sel_edge_s) begin
                    confirm_s = 1'b1;
                    state_s   = LOCKED;
                end else if (next_step_s) begin
                    if (idx_s != LAST_IDX) begin
                        idx_s = idx_s + {{(IW-1){1'b0}}, 1'b1};
                    end else if (WRAP) begin
                        idx_s = {IW{1'b0}};
                    end else begin
                        idx_s = LAST_IDX;
                    end
                end else if (prev_step_s) begin
                    if (idx_s != {IW{1'b0}}) begin
                        idx_s = idx_s - {{(IW-1){1'b0}}, 1'b1};
                    end else if (WRAP) begin
                        idx_s = LAST_IDX;
                    end else begin
                        idx_s = {IW{1'b0}};
                    end
                end else begin
                    state_s = NAV;
                end
            end
            LOCKED: begin
                if (unlock) begin
                    state_s = NAV;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s = NAV;
            end
        endcase
        onehot_s = {NUM_OPTS{1'b0}};
        onehot_s[idx_s[SW-1:0]] = 1'b1;
    end

    // State, index and registered sprite/mode outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prev_key_r <= 8'h00;
            state_r    <= NAV;
            sel_r      <= RESET_SEL;
            cursor_y_r <= cursor_y(Y_BASE, Y_STEP, RESET_IDX);
            onehot_r   <= RESET_ONEHOT;
            confirm_r  <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            prev_key_r <= keycode;
            state_r    <= state_s;
            sel_r      <= idx_s[SW-1:0];
            cursor_y_r <= cursor_y(Y_BASE, Y_STEP, int'(idx_s));
            onehot_r   <= onehot_s;
            confirm_r  <= confirm_s;
            locked_r   <= (state_s == LOCKED);
        end
    end

endmodule

// File: tb/tb_menu_cursor.sv
// Scoreboard bench: three menu_cursor configurations share stimulus and are checked against a frame-level model.
module tb_menu_cursor;

    localparam logic [7:0] KP = 8'h4B;
    localparam logic [7:0] KN = 8'h4E;
    localparam logic [7:0] KS = 8'h28;
    localparam logic [7:0] KX = 8'h11;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode   = 8'h00;
    logic       st        = 1'b0;
    logic       unlock    = 1'b0;

    logic [9:0]  cx0, cx1, cx2, cy0, cy1, cy2;
    logic [1:0]  sel0, sel1;
    logic [3:0]  sel2;
    logic [3:0]  oh0, oh1;
    logic [15:0] oh2;
    logic        cf0, cf1, cf2, lk0, lk1, lk2;

    typedef struct {
        int          inst;
        logic [15:0] sel;
        logic [15:0] y;
        logic [15:0] oh;
        logic [15:0] conf;
        logic [15:0] lock;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_prev, m_hold;
    int m_sel[3];
    bit m_lock[3];
    bit m_conf[3];
    int n_opts[3] = '{4, 4, 16};
    bit m_wrap[3] = '{1'b0, 1'b1, 1'b0};

    always #5 frame_clk = ~frame_clk;

    menu_cursor #(.NUM_OPTS(4), .WRAP(1'b0)) u0 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .st(st), .unlock(unlock),
        .CursorX(cx0), .CursorY(cy0), .sel_idx(sel0), .mode_onehot(oh0), .confirm(cf0), .locked(lk0));
    menu_cursor #(.NUM_OPTS(4), .WRAP(1'b1)) u1 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .st(st), .unlock(unlock),
        .CursorX(cx1), .CursorY(cy1), .sel_idx(sel1), .mode_onehot(oh1), .confirm(cf1), .locked(lk1));
    menu_cursor #(.NUM_OPTS(16), .WRAP(1'b0)) u2 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .st(st), .unlock(unlock),
        .CursorX(cx2), .CursorY(cy2), .sel_idx(sel2), .mode_onehot(oh2), .confirm(cf2), .locked(lk2));

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    // Frame-level reference: hold frames counted from the press edge, repeat at DELAY then every RATE.
    task automatic model_frame(input logic [7:0] kc, input logic s, input logic u, input logic r);
        bit rep_fire, nav, sel_edge;
        exp_t e;
        if (r) begin
            m_prev = 0;
            m_hold = 0;
            for (int i = 0; i < 3; i++) begin
                m_sel[i] = 0; m_lock[i] = 1'b0; m_conf[i] = 1'b0;
            end
        end else begin
            if (int'(kc) == m_prev) m_hold++;
            else m_hold = 0;
            rep_fire = (int'(kc) == m_prev) && (m_hold == 30 || (m_hold > 30 && (m_hold - 30) % 8 == 0));
            nav      = (kc == KP || kc == KN) && (int'(kc) != m_prev || rep_fire);
            sel_edge = (kc == KS) && (m_prev != int'(KS));
            for (int i = 0; i < 3; i++) begin
                m_conf[i] = 1'b0;
                if (m_lock[i]) begin
                    if (u) m_lock[i] = 1'b0;
                end else if (!s) begin
                    if (sel_edge) begin
                        m_conf[i] = 1'b1; m_lock[i] = 1'b1;
                    end else if (nav && kc == KN) begin
                        if (m_sel[i] < n_opts[i] - 1) m_sel[i]++;
                        else if (m_wrap[i]) m_sel[i] = 0;
                    end else if (nav && kc == KP) begin
                        if (m_sel[i] > 0) m_sel[i]--;
                        else if (m_wrap[i]) m_sel[i] = n_opts[i] - 1;
                    end
                end
            end
            m_prev = int'(kc);
        end
        for (int i = 0; i < 3; i++) begin
            e.inst = i;
            e.sel  = 16'(m_sel[i]);
            e.y    = 16'((276 + 64 * m_sel[i]) % 1024);
            e.oh   = 16'(1) << m_sel[i];
            e.conf = {15'd0, m_conf[i]};
            e.lock = {15'd0, m_lock[i]};
            exp_q.push_back(e);
        end
    endtask

    task automatic compare_frame();
        exp_t e;
        logic [15:0] a_sel, a_y, a_oh, a_cf, a_lk;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            case (e.inst)
                0: begin a_sel = {14'd0, sel0}; a_y = {6'd0, cy0}; a_oh = {12'd0, oh0}; a_cf = {15'd0, cf0}; a_lk = {15'd0, lk0}; end
                1: begin a_sel = {14'd0, sel1}; a_y = {6'd0, cy1}; a_oh = {12'd0, oh1}; a_cf = {15'd0, cf1}; a_lk = {15'd0, lk1}; end
                default: begin a_sel = {12'd0, sel2}; a_y = {6'd0, cy2}; a_oh = oh2; a_cf = {15'd0, cf2}; a_lk = {15'd0, lk2}; end
            endcase
            check_eq($sformatf("u%0d.sel_idx", e.inst), a_sel, e.sel);
            check_eq($sformatf("u%0d.CursorY", e.inst), a_y, e.y);
            check_eq($sformatf("u%0d.mode_onehot", e.inst), a_oh, e.oh);
            check_eq($sformatf("u%0d.confirm", e.inst), a_cf, e.conf);
            check_eq($sformatf("u%0d.locked", e.inst), a_lk, e.lock);
        end
    endtask

    task automatic frame(input logic [7:0] kc, input logic s, input logic u, input logic r);
        @(negedge frame_clk);
        keycode = kc; st = s; unlock = u; Reset = r;
        model_frame(kc, s, u, r);
        @(posedge frame_clk);
        #1;
        compare_frame();
    endtask

    task automatic tap(input logic [7:0] kc, input logic s);
        frame(kc, s, 1'b0, 1'b0);
        frame(8'h00, s, 1'b0, 1'b0);
    endtask

    logic [7:0] key_tbl[5] = '{8'h00, KP, KN, KS, KX};

    initial begin
        frame(8'h00, 1'b0, 1'b0, 1'b1);
        frame(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tap(KN, 1'b0);
        // Long hold: 16-entry instance steps at hold frames 0, 30, 38, 46.
        frame(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) frame(KN, 1'b0, 1'b0, 1'b0);
        frame(8'h00, 1'b0, 1'b0, 1'b1);
        tap(KN, 1'b0);
        tap(KS, 1'b0);
        tap(KP, 1'b0);
        frame(8'h00, 1'b0, 1'b1, 1'b0);
        tap(KP, 1'b0);
        tap(KN, 1'b1);
        tap(KS, 1'b1);
        tap(KN, 1'b0);
        tap(KN, 1'b0);
        tap(KS, 1'b0);
        frame(8'h00, 1'b0, 1'b0, 1'b1);
        frame(8'h00, 1'b0, 1'b0, 1'b0);
        // Unlock colliding with a select edge, then a held select, then a fresh edge.
        tap(KS, 1'b0);
        frame(KS, 1'b0, 1'b1, 1'b0);
        frame(KS, 1'b0, 1'b0, 1'b0);
        tap(KS, 1'b0);
        frame(8'h00, 1'b1, 1'b1, 1'b0);
        tap(KX, 1'b0);
        for (int i = 0; i < 5; i++) frame(KN, 1'b0, 1'b0, 1'b0);
        frame(KN, 1'b0, 1'b0, 1'b1);
        frame(KN, 1'b0, 1'b0, 1'b0);
        frame(KN, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 40; b++) begin
            logic [7:0] kc;
            logic       s;
            int         len;
            kc  = key_tbl[$urandom_range(0, 4)];
            s   = ($urandom_range(0, 5) == 0);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 50) : $urandom_range(1, 4);
            for (int k = 0; k < len; k++)
                frame(kc, s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 150) == 0));
        end
        check_eq("u0.CursorX", {6'd0, cx0}, 16'd155);
        check_eq("u1.CursorX", {6'd0, cx1}, 16'd155);
        check_eq("u2.CursorX", {6'd0, cx2}, 16'd155);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
